microop_sequencer: RTL

// Upstream stage of the datapath controller. Accepts one macro-instruction per start

---
 rtl/microop_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/microop_sequencer.sv
// -----------------------------------------------------------------------------
// microop_sequencer
//
// Upstream stage of the datapath controller. One macro-instruction is accepted
// per start handshake and expanded into a timed sequence of micro-op selectors,
// one per clock. The selector sits at NOP_SEL whenever no micro-op is being
// issued, so the downstream datapath holds all of its registers.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      request; sampled only in IDLE
//   opcode    in   3      macro-instruction, latched when start is accepted
//   count     in   CNT_W  shift count for OP_SHR, latched with opcode
//   selector  out  SEL_W  micro-op selector to the controller (registered)
//   busy      out  1      high while a sequence is executing (EXEC state)
//   done      out  1      one-cycle pulse after the last micro-op
//   err       out  1      one-cycle pulse with done for an illegal opcode
//
// Opcode expansion (one selector per cycle, in order)
//   OP_LOAD=0  CLEARLD
//   OP_ACC=1   ADDLD, ADD
//   OP_SHR=2   SHTR x count (count=0 emits nothing)
//   OP_DISP=3  DISP
//   OP_LDSD=4  CLEARLD, ADDLD, SHTR, DISP
//   5..7       illegal: nothing emitted, done and err pulse together
//
// Timing
//   All outputs are registered and change on the same edge as the state, so
//   busy/selector line up exactly with the EXEC cycles. A k-step sequence
//   occupies k cycles of EXEC, then one DONE cycle, then at least one IDLE
//   cycle before the next start can be taken (minimum period k+2).
// -----------------------------------------------------------------------------
module microop_sequencer #(
    parameter int               SEL_W   = 5,
    parameter int               CNT_W   = 4,
    parameter logic [SEL_W-1:0] NOP_SEL = {SEL_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [CNT_W-1:0] count,
    output logic [SEL_W-1:0] selector,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // -------------------------------------------------------------------------
    // Encodings
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ACC  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_DISP = 3'd3;
    localparam logic [2:0] OP_LDSD = 3'd4;

    localparam logic [SEL_W-1:0] UOP_CLEARLD = SEL_W'(0);
    localparam logic [SEL_W-1:0] UOP_ADDLD   = SEL_W'(1);
    localparam logic [SEL_W-1:0] UOP_ADD     = SEL_W'(2);
    localparam logic [SEL_W-1:0] UOP_SHTR    = SEL_W'(3);
    localparam logic [SEL_W-1:0] UOP_DISP    = SEL_W'(4);

    // -------------------------------------------------------------------------
    // Sequence tables
    // -------------------------------------------------------------------------

    // Selector issued at a given step of a given opcode.
    function automatic logic [SEL_W-1:0] step_sel(
        input logic [2:0] op,
        input logic [1:0] step
    );
        logic [SEL_W-1:0] sel;
        // NOTE: give every local a default before the case so no path leaves
        // it unassigned; the same habit keeps combinational blocks latch-free.
        sel = NOP_SEL;
        case (op)
            OP_LOAD: sel = UOP_CLEARLD;
            OP_ACC:  sel = (step == 2'd0) ? UOP_ADDLD : UOP_ADD;
            OP_SHR:  sel = UOP_SHTR;
            OP_DISP: sel = UOP_DISP;
            OP_LDSD: begin
                case (step)
                    2'd0:    sel = UOP_CLEARLD;
                    2'd1:    sel = UOP_ADDLD;
                    2'd2:    sel = UOP_SHTR;
                    default: sel = UOP_DISP;
                endcase
            end
            default: sel = NOP_SEL;
        endcase
        return sel;
    endfunction

    // True when the step currently on the selector is the final one.
    // For OP_SHR the remaining count is used instead of the step index, so
    // long shifts never need a wide step counter.
    function automatic logic step_last(
        input logic [2:0]       op,
        input logic [1:0]       step,
        input logic [CNT_W-1:0] remaining
    );
        logic last;
        last = 1'b1;
        case (op)
            OP_ACC:  last = (step == 2'd1);
            OP_SHR:  last = (remaining == CNT_W'(1));
            OP_LDSD: last = (step == 2'd3);
            default: last = 1'b1;
        endcase
        return last;
    endfunction

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [2:0]       r_opcode;
    logic [1:0]       r_step;
    logic [CNT_W-1:0] r_remaining;
    logic [SEL_W-1:0] r_selector;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // -------------------------------------------------------------------------
    // Next-step decode
    // -------------------------------------------------------------------------
    logic             w_illegal;
    logic             w_zero_len;
    logic [SEL_W-1:0] w_first_sel;
    logic             w_last;
    logic [1:0]       w_step_next;
    logic [SEL_W-1:0] w_next_sel;

    // Decode of the incoming request (used only in IDLE).
    assign w_illegal   = (opcode > OP_LDSD);
    assign w_zero_len  = w_illegal || ((opcode == OP_SHR) && (count == '0));
    assign w_first_sel = step_sel(opcode, 2'd0);

    // Decode of the latched request (used only in EXEC).
    assign w_last      = step_last(r_opcode, r_step, r_remaining);
    assign w_step_next = r_step + 2'd1;
    assign w_next_sel  = step_sel(r_opcode, w_step_next);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_step      <= '0;
            r_remaining <= '0;
            r_selector  <= NOP_SEL;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_selector <= NOP_SEL;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    if (start) begin
                        r_opcode    <= opcode;
                        r_step      <= '0;
                        r_remaining <= count;
                        if (w_zero_len) begin
                            // Nothing to emit: report completion right away.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= w_illegal;
                        end else begin
                            r_state    <= S_EXEC;
                            r_busy     <= 1'b1;
                            r_selector <= w_first_sel;
                        end
                    end
                end

                S_EXEC: begin
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_selector <= NOP_SEL;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_step     <= w_step_next;
                        r_selector <= w_next_sel;
                        // Count down one per SHTR issued; the exit at 1 means
                        // the counter never wraps.
                        if (r_opcode == OP_SHR) begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    // start is deliberately not sampled here; a held start is
                    // taken on the following IDLE cycle.
                    r_state    <= S_IDLE;
                    r_selector <= NOP_SEL;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_selector <= NOP_SEL;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                end
            endcase
        end
    end

    assign selector = r_selector;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
